clk_div_bank: RTL
=================

# clk_div_bank

Parametrised bank of NCH independent clock-enable generators, all running from clk_24M. It replaces the fixed fifo, debounce and anode dividers with one block. Each channel produces a one-cycle tick strobe and a duty-programmable level output. Divide ratio and high time can be reloaded at runtime without glitches, and a resync input phase-aligns all channels.

## Interface
- NCH, 4, number of channels
- CW, 21, counter/config width (holds 1,200,000)
- CHW, 2, width of cfg_ch
- DIV_INIT, {21'd2400, 21'd24000, 21'd1200000, 21'd24}, packed NCH*CW reset divide values; channel 0 in the LSBs (ch0 1 MHz, ch1 20 Hz, ch2 1 kHz, ch3 10 kHz)
- HIGH_INIT, {21'd1, 21'd1, 21'd1, 21'd12}, packed NCH*CW reset high times

Ports:
- clk_24M  in  1  24 MHz clock
- reset  in  1  Synchronous, active-high
- ch_en  in  NCH  Per-channel run enable
- resync  in  1  Single-cycle pulse; zero all counters
- cfg_we  in  1  Config write strobe
- cfg_ch  in  CHW  Target channel
- cfg_div  in  CW  New period in cycles
- cfg_high  in  CW  New high time in cycles
- tick  out  NCH  One-cycle strobe per period
- level  out  NCH  Duty-cycle output
- cfg_pend  out  NCH  Shadow written, not yet active
- cfg_err  out  1  One-cycle pulse on a rejected write

## Operation
- Per-channel registers:
  - run: ch_en sampled every edge.
  - cnt: CW bits.
  - div_act / high_act: active configuration.
  - div_sh / high_sh: shadow configuration.
  - pend: shadow waiting to be applied.
- Counter update, in priority order:
  - reset: cnt=0.
  - resync or run=0: cnt=0.
  - cnt==div_act-1: cnt=0 (wrap).
  - Otherwise: cnt+1.
- Outputs are pure decodes of registered state; there is no combinational path from any input:
  - tick = run & (cnt==0)
  - level = run & (cnt < high_act)
- The level comparison is unsigned, which gives these edge cases:
  - high_act=0: level always low.
  - high_act>=div_act: level always high while running.
- Config write rules:
  - Accept when cfg_we=1, cfg_ch<NCH and cfg_div>=2. On accept, div_sh/high_sh are loaded and pend=1.
  - Reject otherwise: cfg_err pulses high the next cycle and no state changes.
  - A second write to a pending channel overwrites the shadow; pend stays 1.
- Shadow apply: div_act/high_act load from the shadow and pend clears on any edge where pend=1 and one of these holds:
  - the counter wraps;
  - resync=1;
  - run=0.
- Simultaneous write and apply on the same channel: the apply uses the old shadow contents. The new write then lands in the shadow and pend stays 1.
- Reset values:
  - cnt=0, run=0, pend=0.
  - act and shadow registers = DIV_INIT/HIGH_INIT.
  - tick=0, level=0, cfg_pend=0, cfg_err=0.

## Timing
- Reset released with ch_en=1: run=1 after the first edge, giving tick in cycle 1, then cycles 1+DIV, 1+2·DIV, …
- level is high for high_act cycles starting with the tick cycle.
- ch_en falling: outputs go low in the cycle after the edge that samples it. Re-enable: tick in the first cycle with run=1.
- resync sampled at edge k: every running channel ticks in cycle k+1, so all channels are phase-aligned.
- A new configuration becomes visible starting in the cycle after the wrap edge. The period in progress always completes with the old values, so there is no runt or stretched pulse.
- cfg_pend mirrors the pend register; cfg_err is registered with 1-cycle latency.
- Reset mid-operation: all shadows revert to INIT and pending writes are discarded.
- Wrap: cnt never exceeds div_act-1. The CW-bit counter never overflows, because div_act < 2^CW always holds.

## Test plan
- Reset, then ch_en=4'b1111 → ch0 tick at cycles 1, 25, 49; ch0 level high for cycles 1–12, low for 13–24; ch1 tick at cycles 1 and 1,200,001.
- Ch0 write div=10, high=3 at cnt=5 → cfg_pend[0]=1 until the wrap edge. Old 24-cycle period completes, then ticks every 10 cycles with level high 3 cycles; no other channel disturbed.
- cfg_div=1 on ch2 → cfg_err pulses for one cycle and config is unchanged. cfg_ch=3 with div=0 → cfg_err. NCH=3 build with cfg_ch=3 → cfg_err.
- resync at an arbitrary cycle k with all channels running → tick=4'b1111 in cycle k+1. Same-cycle resync plus ch0 write → old shadow applied, cfg_pend[0] stays 1.
- ch_en[0] dropped mid-period → tick[0]/level[0] low next cycle. A pending ch0 write applies while idle. Re-enable → tick[0] on the first cycle with the new period.
- Ch1 write pending, then reset pulse → cfg_pend=0; after release ch1 still ticks every 1,200,000 cycles.

Source files
------------

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//
// Bank of NCH independent clock-enable generators running from clk_24M.
// Each channel counts 0 .. div_act-1 and produces:
//   tick  : one-cycle strobe while cnt == 0
//   level : high while cnt < high_act (duty-cycle output)
// Divide ratio and high time are written into a per-channel shadow and only
// become active at a period boundary (wrap), on resync, or while the channel
// is idle. A period in progress therefore always completes with its old
// values, so the outputs never show a runt or stretched pulse.
//
// Ports
//   clk_24M   in   24 MHz clock
//   reset     in   synchronous, active-high
//   ch_en     in   [NCH]  per-channel run enable (registered into run_q)
//   resync    in   single-cycle pulse, zeroes every counter
//   cfg_we    in   config write strobe
//   cfg_ch    in   [CHW]  target channel
//   cfg_div   in   [CW]   new period in cycles (must be >= 2)
//   cfg_high  in   [CW]   new high time in cycles
//   tick      out  [NCH]  one-cycle strobe per period
//   level     out  [NCH]  duty-cycle output
//   cfg_pend  out  [NCH]  shadow written, not yet active
//   cfg_err   out  one-cycle pulse, the cycle after a rejected write
//
// Config handshake: cfg_we is a fire-and-forget strobe with no ready. Every
// edge with cfg_we=1 either accepts the write (shadow loaded, pend set) or
// rejects it (cfg_err pulses next cycle, no state change); there is no
// back-pressure and no write is ever held over to a later edge.
// -----------------------------------------------------------------------------
module clk_div_bank #(
   parameter int                  NCH       = 4,
   parameter int                  CW        = 21,
   parameter int                  CHW       = 2,
   parameter logic [NCH*CW-1:0]   DIV_INIT  = {21'd2400, 21'd24000, 21'd1200000, 21'd24},
   parameter logic [NCH*CW-1:0]   HIGH_INIT = {21'd1, 21'd1, 21'd1, 21'd12}
) (
   input  logic              clk_24M,
   input  logic              reset,
   input  logic [NCH-1:0]    ch_en,
   input  logic              resync,
   input  logic              cfg_we,
   input  logic [CHW-1:0]    cfg_ch,
   input  logic [CW-1:0]     cfg_div,
   input  logic [CW-1:0]     cfg_high,
   output logic [NCH-1:0]    tick,
   output logic [NCH-1:0]    level,
   output logic [NCH-1:0]    cfg_pend,
   output logic              cfg_err
);

   // One extra bit so a channel index equal to a non-power-of-two NCH is
   // still representable in the range check.
   localparam logic [CHW:0]  NCH_LIM = (CHW+1)'(NCH);
   localparam logic [CW-1:0] DIV_MIN = CW'(2);

   logic [NCH-1:0] run_q,  run_d;
   logic [NCH-1:0] pend_q, pend_d;
   logic [CW-1:0]  cnt_q      [NCH];
   logic [CW-1:0]  cnt_d      [NCH];
   logic [CW-1:0]  div_act_q  [NCH];
   logic [CW-1:0]  div_act_d  [NCH];
   logic [CW-1:0]  high_act_q [NCH];
   logic [CW-1:0]  high_act_d [NCH];
   logic [CW-1:0]  div_sh_q   [NCH];
   logic [CW-1:0]  div_sh_d   [NCH];
   logic [CW-1:0]  high_sh_q  [NCH];
   logic [CW-1:0]  high_sh_d  [NCH];
   logic           cfg_err_q, cfg_err_d;

   logic           cfg_ok;
   logic [NCH-1:0] wr_w;
   logic [NCH-1:0] wrap_w;
   logic [NCH-1:0] apply_w;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      cfg_ok    = cfg_we && ({1'b0, cfg_ch} < NCH_LIM) && (cfg_div >= DIV_MIN);
      cfg_err_d = cfg_we && !cfg_ok;
      run_d     = ch_en;
      wr_w      = '0;
      wrap_w    = '0;
      apply_w   = '0;
      pend_d    = pend_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i]      = cnt_q[i];
         div_act_d[i]  = div_act_q[i];
         high_act_d[i] = high_act_q[i];
         div_sh_d[i]   = div_sh_q[i];
         high_sh_d[i]  = high_sh_q[i];

         wr_w[i]    = cfg_ok && (cfg_ch == CHW'(i));
         wrap_w[i]  = (cnt_q[i] == div_act_q[i] - CW'(1));
         apply_w[i] = pend_q[i] && (wrap_w[i] || resync || !run_q[i]);

         if (resync || !run_q[i] || wrap_w[i]) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end

         // Apply reads the shadow as it stood before this edge, so a write on
         // the same edge lands afterwards and stays pending.
         if (apply_w[i]) begin
            div_act_d[i]  = div_sh_q[i];
            high_act_d[i] = high_sh_q[i];
         end
         if (wr_w[i]) begin
            div_sh_d[i]  = cfg_div;
            high_sh_d[i] = cfg_high;
         end
         pend_d[i] = wr_w[i] || (pend_q[i] && !apply_w[i]);
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_24M) begin
      if (reset) begin
         run_q     <= '0;
         pend_q    <= '0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]      <= '0;
            div_act_q[i]  <= DIV_INIT[i*CW +: CW];
            high_act_q[i] <= HIGH_INIT[i*CW +: CW];
            div_sh_q[i]   <= DIV_INIT[i*CW +: CW];
            high_sh_q[i]  <= HIGH_INIT[i*CW +: CW];
         end
      end else begin
         run_q     <= run_d;
         pend_q    <= pend_d;
         cfg_err_q <= cfg_err_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]      <= cnt_d[i];
            div_act_q[i]  <= div_act_d[i];
            high_act_q[i] <= high_act_d[i];
            div_sh_q[i]   <= div_sh_d[i];
            high_sh_q[i]  <= high_sh_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decodes of registered state only
   // ---------------------------------------------------------------------------
   always_comb begin
      tick  = '0;
      level = '0;
      for (int i = 0; i < NCH; i++) begin
         tick[i]  = run_q[i] && (cnt_q[i] == '0);
         level[i] = run_q[i] && (cnt_q[i] < high_act_q[i]);
      end
   end

   assign cfg_pend = pend_q;
   assign cfg_err  = cfg_err_q;

endmodule
